// File: rtl/maxpool_stream_if.sv
// Stream bundle for maxpool_stream: raster pixel input, pooled pixel output
// and the end-of-frame pulse.
interface maxpool_stream_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              frame_done;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_last, frame_done
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_last, frame_done
    );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 3x3 / stride-2 signed max-pool over one W_IN x W_IN channel.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to zero.
module maxpool_stream #(
    parameter int W_IN   = 55,
    parameter int DATA_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    maxpool_stream_if.slave  bus
);
    localparam int W_OUT = (W_IN - 3) / 2 + 1;
    localparam int CW    = $clog2(W_IN);
    localparam bit EXCESS = (W_IN % 2) == 0;
    localparam logic [CW-1:0] LAST_POS = CW'(2 * W_OUT);
    localparam logic [CW-1:0] MAX_POS  = CW'(W_IN - 1);

    typedef logic signed [DATA_W-1:0] pix_t;
    typedef enum logic [1:0] {RUN, LAST, DONE} state_t;

    function automatic pix_t smax(input pix_t a, input pix_t b);
        return (a > b) ? a : b;
    endfunction

    state_t        state, state_nxt;
    logic [CW-1:0] in_row, in_col;
    logic          run_en;
    pix_t          lb0 [W_IN];
    pix_t          lb1 [W_IN];
    pix_t          x, rd, vcol, hacc, hmax, res, m_data_q;
    logic          m_valid_q, m_last_q;
    logic          s_ready_c, frame_done_c;
    logic          in_xfer, out_xfer, win_done, win_final;
    logic          wr_sel, rd_sel;

    assign x        = pix_t'(bus.s_data);
    assign in_xfer  = bus.s_valid && s_ready_c;
    assign out_xfer = m_valid_q && bus.m_ready;

    // Banks alternate per window row: odd rows extend the current bank, the
    // shared even row closes the other bank's window and seeds its own.
    assign wr_sel = in_row[1];
    assign rd_sel = in_row[0] ? in_row[1] : ~in_row[1];
    assign rd     = rd_sel ? lb1[in_col] : lb0[in_col];
    assign vcol   = smax(rd, x);
    assign hmax   = smax(hacc, vcol);

    assign win_done  = in_xfer && !in_row[0] && !in_col[0] && (in_row != '0) && (in_col != '0);
    assign win_final = (in_row == LAST_POS) && (in_col == LAST_POS);

`ifdef MAXPOOL_RELU_EN
    assign res = hmax[DATA_W-1] ? '0 : hmax;
`else
    assign res = hmax;
`endif

    always_ff @(posedge clk) begin
        if (in_xfer) begin
            if (wr_sel) lb1[in_col] <= in_row[0] ? vcol : x;
            else        lb0[in_col] <= in_row[0] ? vcol : x;
        end
    end

    // Horizontal accumulator restarts on every even column, closing a window there.
    always_ff @(posedge clk) begin
        if (in_xfer) hacc <= in_col[0] ? hmax : vcol;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_en <= 1'b0;
            in_row <= '0;
            in_col <= '0;
        end else begin
            run_en <= 1'b1;
            // With an even width the trailing column/row is still owed after
            // the final window, so the counters keep their place until wrap.
            if (state == DONE && !EXCESS) begin
                in_row <= '0;
                in_col <= '0;
            end else if (in_xfer) begin
                if (in_col == MAX_POS) begin
                    in_col <= '0;
                    in_row <= (in_row == MAX_POS) ? '0 : in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
        end else if (win_done) begin
            m_valid_q <= 1'b1;
            m_data_q  <= res;
            m_last_q  <= win_final;
        end else if (out_xfer) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        s_ready_c    = 1'b0;
        frame_done_c = 1'b0;
        case (state)
            RUN: begin
                s_ready_c = run_en && (!m_valid_q || bus.m_ready);
                if (win_done && win_final) state_nxt = LAST;
            end
            LAST: begin
                if (out_xfer) state_nxt = DONE;
            end
            DONE: begin
                frame_done_c = 1'b1;
                state_nxt    = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign bus.s_ready    = s_ready_c;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_last     = m_last_q;
    assign bus.frame_done = frame_done_c;
endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: W_IN=5 and W_IN=55 instances checked against a
// brute-force 3x3/stride-2 pooling model.
module tb_maxpool_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maxpool_stream_if #(.DATA_W(16)) ifa ();
    maxpool_stream_if #(.DATA_W(16)) ifb ();

    maxpool_stream #(.W_IN(5),  .DATA_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    maxpool_stream #(.W_IN(55), .DATA_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] outs_a[$];
    logic [15:0] outs_b[$];
    int          pix[3025];
    int          total = 0;
    int          bad = 0;
    int          n_out_a = 0, n_last_a = 0, n_done_a = 0, n_out_b = 0;
    logic        lastx_a = 0, lastx_b = 0, hold_a = 0, hold_b = 0;
    logic [15:0] hold_da, hold_db;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each output is the plain maximum of its 3x3 window.
    task automatic model(input int w, input int base, input bit to_b);
        int   wo;
        int   m;
        int   v;
        exp_t e;
        wo = (w - 3) / 2 + 1;
        for (int r = 0; r < wo; r++)
            for (int c = 0; c < wo; c++) begin
                m = -100000;
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++) begin
                        v = pix[base + (2*r + dr) * w + 2*c + dc];
                        if (v > m) m = v;
                    end
`ifdef MAXPOOL_RELU_EN
                if (m < 0) m = 0;
`endif
                e.d = 16'(m);
                e.l = (r == wo - 1) && (c == wo - 1);
                if (to_b) qb.push_back(e);
                else      qa.push_back(e);
            end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            lastx_a = 0;
            hold_a  = 0;
        end else begin
            chk("a_done_pulse", ifa.frame_done, lastx_a);
            if (ifa.frame_done) begin
                n_done_a++;
                chk("a_done_sready", ifa.s_ready, 0);
            end
            lastx_a = 0;
            if (hold_a) begin
                chk("a_hold_valid", ifa.m_valid, 1);
                chk("a_hold_data", ifa.m_data, hold_da);
            end
            hold_a  = ifa.m_valid && !ifa.m_ready;
            hold_da = ifa.m_data;
            if (ifa.m_valid && ifa.m_last) chk("a_last_sready", ifa.s_ready, 0);
            if (ifa.m_valid && ifa.m_ready) begin
                n_out_a++;
                outs_a.push_back(ifa.m_data);
                chk("a_expected_output", (qa.size() > 0), 1);
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_data", ifa.m_data, e.d);
                    chk("a_last", ifa.m_last, e.l);
                end
                if (ifa.m_last) begin
                    n_last_a++;
                    lastx_a = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            lastx_b = 0;
            hold_b  = 0;
        end else begin
            chk("b_done_pulse", ifb.frame_done, lastx_b);
            lastx_b = 0;
            if (hold_b) chk("b_hold_data", ifb.m_data, hold_db);
            hold_b  = ifb.m_valid && !ifb.m_ready;
            hold_db = ifb.m_data;
            if (ifb.m_valid && ifb.m_ready) begin
                n_out_b++;
                outs_b.push_back(ifb.m_data);
                chk("b_expected_output", (qb.size() > 0), 1);
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_data", ifb.m_data, e.d);
                    chk("b_last", ifb.m_last, e.l);
                end
                if (ifb.m_last) lastx_b = 1;
            end
        end
    end

    task automatic send_a(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            int t = 0;
            if (gaps) repeat ($urandom_range(0, 2)) begin
                ifa.s_valid = 0;
                @(posedge clk); #1;
            end
            ifa.s_valid = 1;
            ifa.s_data  = 16'(pix[k]);
            @(negedge clk);
            while (!ifa.s_ready && t < 200) begin
                t++;
                @(negedge clk);
            end
            chk("a_accept", (t < 200), 1);
            @(posedge clk); #1;
        end
        ifa.s_valid = 0;
    endtask

    // rmode: 0 = m_ready high, 1 = random m_ready, 2 = stall 10 cycles on first output
    task automatic run_a(input int n, input bit gaps, input int rmode);
        bit sent = 0;
        fork
            begin
                send_a(n, gaps);
                sent = 1;
            end
            begin
                int t = 0;
                ifa.m_ready = (rmode != 2);
                if (rmode == 2) begin
                    @(negedge clk);
                    while (!ifa.m_valid && t < 500) begin
                        t++;
                        @(negedge clk);
                    end
                    chk("a_first_valid", ifa.m_valid, 1);
                    for (int i = 0; i < 10; i++) begin
                        chk("a_stall_sready", ifa.s_ready, 0);
                        chk("a_stall_data", ifa.m_data, 16'd12);
                        @(negedge clk);
                    end
                    @(posedge clk); #1;
                    ifa.m_ready = 1;
                end
                t = 0;
                while (!(sent && qa.size() == 0) && t < 3000) begin
                    @(posedge clk); #1;
                    if (rmode == 1) ifa.m_ready = 1'($urandom_range(0, 1));
                    t++;
                end
                ifa.m_ready = 1;
            end
        join
        chk("a_drained", qa.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_b(input int n, input bit rnd);
        bit sent = 0;
        fork
            begin
                for (int k = 0; k < n; k++) begin
                    int t = 0;
                    if (rnd) repeat ($urandom_range(0, 1)) begin
                        ifb.s_valid = 0;
                        @(posedge clk); #1;
                    end
                    ifb.s_valid = 1;
                    ifb.s_data  = 16'(pix[k]);
                    @(negedge clk);
                    while (!ifb.s_ready && t < 200) begin
                        t++;
                        @(negedge clk);
                    end
                    if (t >= 200) chk("b_accept", (t < 200), 1);
                    @(posedge clk); #1;
                end
                ifb.s_valid = 0;
                sent = 1;
            end
            begin
                int t = 0;
                while (!(sent && qb.size() == 0) && t < 20000) begin
                    @(posedge clk); #1;
                    ifb.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    t++;
                end
                ifb.m_ready = 1;
            end
        join
        chk("b_drained", qb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp(input int base);
        for (int i = 0; i < 25; i++) pix[base + i] = i;
    endtask

    task automatic check_ramp(input string tag);
        chk({tag, "_count"}, outs_a.size(), 4);
        if (outs_a.size() == 4) begin
            chk({tag, "_o0"}, outs_a[0], 16'd12);
            chk({tag, "_o1"}, outs_a[1], 16'd14);
            chk({tag, "_o2"}, outs_a[2], 16'd22);
            chk({tag, "_o3"}, outs_a[3], 16'd24);
        end
    endtask

    initial begin
        int nl, nd, nz;
        logic [15:0] neg_exp;
        ifa.s_valid = 0; ifa.s_data = 0; ifa.m_ready = 1;
        ifb.s_valid = 0; ifb.s_data = 0; ifb.m_ready = 1;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", ifa.m_valid, 0);
        chk("rst_m_last", ifa.m_last, 0);
        chk("rst_frame_done", ifa.frame_done, 0);
        chk("rst_s_ready", ifa.s_ready, 0);
        chk("rst_b_s_ready", ifb.s_ready, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rst_release_lo", ifa.s_ready, 0);
        @(negedge clk);
        chk("rst_release_hi", ifa.s_ready, 1);
        @(posedge clk); #1;

        // ramp frame, free-running output
        fill_ramp(0); model(5, 0, 0); outs_a.delete();
        nl = n_last_a; nd = n_done_a;
        run_a(25, 0, 0);
        check_ramp("ramp");
        chk("ramp_last_cnt", n_last_a - nl, 1);
        chk("ramp_done_cnt", n_done_a - nd, 1);

        // all -256
        for (int i = 0; i < 25; i++) pix[i] = -256;
        model(5, 0, 0); outs_a.delete();
        run_a(25, 0, 0);
`ifdef MAXPOOL_RELU_EN
        neg_exp = 16'h0000;
`else
        neg_exp = 16'hFF00;
`endif
        chk("neg_count", outs_a.size(), 4);
        foreach (outs_a[i]) chk("neg_value", outs_a[i], neg_exp);

        // downstream stall on the first output
        fill_ramp(0); model(5, 0, 0); outs_a.delete();
        run_a(25, 0, 2);
        check_ramp("stall");

        // reset after 7 pixels, then a clean frame
        fill_ramp(0); outs_a.delete();
        send_a(7, 0);
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        model(5, 0, 0);
        run_a(25, 0, 0);
        check_ramp("mid_reset");

        // two frames back to back with s_valid held high
        fill_ramp(0); fill_ramp(25);
        model(5, 0, 0); model(5, 25, 0); outs_a.delete();
        nl = n_last_a; nd = n_done_a;
        run_a(50, 0, 0);
        chk("b2b_count", outs_a.size(), 8);
        chk("b2b_last_cnt", n_last_a - nl, 2);
        chk("b2b_done_cnt", n_done_a - nd, 2);

        // random frames: full range, then narrow range to provoke ties
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 25; i++)
                pix[i] = (f < 2) ? int'($signed(16'($urandom))) : int'($urandom_range(0, 6)) - 3;
            model(5, 0, 0);
            run_a(25, 1, 1);
        end

        // W_IN=55 single spike
        for (int i = 0; i < 3025; i++) pix[i] = 0;
        pix[2 * 55 + 2] = 32767;
        model(55, 0, 1); outs_b.delete();
        nl = n_out_b;
        run_b(3025, 0);
        chk("spike_count", n_out_b - nl, 729);
        if (outs_b.size() == 729) begin
            chk("spike_00", outs_b[0], 16'h7FFF);
            chk("spike_01", outs_b[1], 16'h7FFF);
            chk("spike_10", outs_b[27], 16'h7FFF);
            chk("spike_11", outs_b[28], 16'h7FFF);
            nz = 0;
            foreach (outs_b[i]) if (outs_b[i] != 16'h0) nz++;
            chk("spike_nonzero", nz, 4);
        end

        // W_IN=55 random frame with random handshakes
        for (int i = 0; i < 3025; i++) pix[i] = int'($signed(16'($urandom)));
        model(55, 0, 1);
        run_b(3025, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
